// File: rtl/mac_mul_sign_restore.sv
// Re-applies the operand sign to unsigned lane products coming out of the multiplier array.
// Define MAC_SIGN_RESTORE_CFG_OUT_EN to add the cfg_out port carrying the result's delayed cfg.
module mac_mul_sign_restore #(
  parameter int unsigned MAC_CONF_WIDTH = 4,
  parameter int unsigned MAC_MIN_WIDTH  = 8,
  parameter int unsigned MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
  parameter int unsigned MUL_LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic                      C0_neg,
  input  logic                      C1_neg,
  input  logic                      C2_neg,
  input  logic                      C3_neg,
  input  logic [MAC_MULT_WIDTH-1:0] P0_in,
  input  logic [MAC_MULT_WIDTH-1:0] P1_in,
  input  logic [MAC_MULT_WIDTH-1:0] P2_in,
  input  logic [MAC_MULT_WIDTH-1:0] P3_in,
  output logic                      out_valid,
  output logic [MAC_MULT_WIDTH-1:0] R0_out,
  output logic [MAC_MULT_WIDTH-1:0] R1_out,
  output logic [MAC_MULT_WIDTH-1:0] R2_out,
  output logic [MAC_MULT_WIDTH-1:0] R3_out
`ifdef MAC_SIGN_RESTORE_CFG_OUT_EN
  ,
  output logic [MAC_CONF_WIDTH-1:0] cfg_out
`endif
);

  // Sideband delay line: stage 0 takes the issue, stage MUL_LATENCY-1 is the head.
  logic [MUL_LATENCY-1:0]    vld_q;
  logic [MAC_CONF_WIDTH-1:0] cfg_q [MUL_LATENCY];
  logic [3:0]                neg_q [MUL_LATENCY];

  logic                      head_vld;
  logic [MAC_CONF_WIDTH-1:0] head_cfg;
  logic [3:0]                head_neg;

  logic [3:0][MAC_MULT_WIDTH-1:0] p_in;
  logic [3:0][MAC_MULT_WIDTH-1:0] r_d;
  logic [3:0][MAC_MULT_WIDTH-1:0] r_q;
  logic                           out_valid_q;

  logic       mode_quad;
  logic       mode_dual;
  logic       mode_single;
  logic [3:0] neg;
  logic [3:0] cin;
  logic [2:0] cout;

  assign p_in = {P3_in, P2_in, P1_in, P0_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        cfg_q[i] <= '0;
        neg_q[i] <= '0;
      end
    end else if (en) begin
      vld_q[0] <= in_valid;
      cfg_q[0] <= in_valid ? cfg : '0;
      neg_q[0] <= in_valid ? {C3_neg, C2_neg, C1_neg, C0_neg} : 4'b0000;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        cfg_q[i] <= cfg_q[i-1];
        neg_q[i] <= neg_q[i-1];
      end
    end
  end

  assign head_vld = vld_q[MUL_LATENCY-1];
  assign head_cfg = cfg_q[MUL_LATENCY-1];
  assign head_neg = neg_q[MUL_LATENCY-1];

  always_comb begin
    mode_quad   = (head_cfg[1:0] == 2'b10);
    mode_dual   = (head_cfg[1:0] == 2'b01);
    mode_single = !mode_quad && !mode_dual;

    // In wide modes every lane of a group follows the group's top-lane flag.
    neg[0] = mode_single ? head_neg[0] : (mode_dual ? head_neg[1] : head_neg[3]);
    neg[1] = mode_quad ? head_neg[3] : head_neg[1];
    neg[2] = mode_single ? head_neg[2] : head_neg[3];
    neg[3] = head_neg[3];
    neg    = neg & {4{head_cfg[3]}};

    // ~P + cin carries out only when the lane is all-zero; chain breaks at group boundaries.
    cin[0]  = 1'b1;
    cout[0] = (p_in[0] == '0) & cin[0];
    cin[1]  = mode_single | cout[0];
    cout[1] = (p_in[1] == '0) & cin[1];
    cin[2]  = mode_quad ? cout[1] : 1'b1;
    cout[2] = (p_in[2] == '0) & cin[2];
    cin[3]  = mode_single | cout[2];

    r_d = p_in;
    for (int i = 0; i < 4; i++) begin
      if (neg[i]) begin
        r_d[i] = ~p_in[i] + MAC_MULT_WIDTH'(cin[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
    end else if (en) begin
      out_valid_q <= head_vld;
      if (head_vld) begin
        r_q <= r_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign R0_out    = r_q[0];
  assign R1_out    = r_q[1];
  assign R2_out    = r_q[2];
  assign R3_out    = r_q[3];

`ifdef MAC_SIGN_RESTORE_CFG_OUT_EN
  logic [MAC_CONF_WIDTH-1:0] cfg_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_out_q <= '0;
    end else if (en && head_vld) begin
      cfg_out_q <= head_cfg;
    end
  end

  assign cfg_out = cfg_out_q;
`else
  // The mac/mul bit only travels along for cfg_out; without that port it is dropped here.
  logic unused_head_cfg;
  assign unused_head_cfg = ^head_cfg;
`endif

endmodule

// File: tb/tb_mac_mul_sign_restore.sv
// Randomized and directed bench for mac_mul_sign_restore against a wide-arithmetic reference model.
module tb_mac_mul_sign_restore;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  cfg = '0;
  logic [3:0]  c_neg = '0;
  logic [63:0] p_all = '0;
  logic        out_valid;
  logic [15:0] r0, r1, r2, r3;
  logic [63:0] r_all;
  logic [3:0]  cfg_out_obs;

  always #5 clk = ~clk;

  mac_mul_sign_restore #(
    .MAC_CONF_WIDTH(4),
    .MAC_MIN_WIDTH (8),
    .MAC_MULT_WIDTH(16),
    .MUL_LATENCY   (L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .cfg      (cfg),
    .C0_neg   (c_neg[0]),
    .C1_neg   (c_neg[1]),
    .C2_neg   (c_neg[2]),
    .C3_neg   (c_neg[3]),
    .P0_in    (p_all[15:0]),
    .P1_in    (p_all[31:16]),
    .P2_in    (p_all[47:32]),
    .P3_in    (p_all[63:48]),
    .out_valid(out_valid),
    .R0_out   (r0),
    .R1_out   (r1),
    .R2_out   (r2),
`ifdef MAC_SIGN_RESTORE_CFG_OUT_EN
    .R3_out   (r3),
    .cfg_out  (cfg_out_obs)
`else
    .R3_out   (r3)
`endif
  );

`ifndef MAC_SIGN_RESTORE_CFG_OUT_EN
  assign cfg_out_obs = 4'h0;
`endif
  assign r_all = {r3, r2, r1, r0};

  typedef struct {
    int          idx;
    logic [3:0]  c;
    logic [3:0]  f;
    logic [63:0] p;
  } txn_t;

  txn_t        pend[$];
  int          ecyc = 0;
  logic        exp_valid = 1'b0;
  logic [63:0] exp_r = '0;
  logic [3:0]  exp_cfg = '0;
  int          nchk = 0;
  int          nbad = 0;

  // Signed result as plain two's-complement negation of the group-wide value.
  function automatic logic [63:0] ref_result(logic [3:0] c, logic [3:0] f, logic [63:0] p);
    logic [63:0] r;
    r = p;
    if (c[3]) begin
      if (c[1:0] == 2'b10) begin
        if (f[3]) r = 64'd0 - p;
      end else if (c[1:0] == 2'b01) begin
        for (int h = 0; h < 2; h++)
          if (f[2*h+1]) r[32*h +: 32] = 32'd0 - p[32*h +: 32];
      end else begin
        for (int i = 0; i < 4; i++)
          if (f[i]) r[16*i +: 16] = 16'd0 - p[16*i +: 16];
      end
    end
    return r;
  endfunction

  // Drives one cycle, presents the product of the issue due at the next enabled edge,
  // and advances the expected output state. Returns #1 after the rising edge.
  task automatic cycle(input logic e, input logic iv, input logic rs, input logic [3:0] c,
                       input logic [3:0] f, input logic [63:0] p);
    @(negedge clk);
    rst = rs; en = e; in_valid = iv; cfg = c; c_neg = f;
    if (e && pend.size() > 0 && pend[0].idx + L == ecyc + 1) p_all = pend[0].p;
    else p_all = {$urandom, $urandom};
    @(posedge clk);
    if (rs) begin
      pend.delete();
      exp_valid = 1'b0; exp_r = '0; exp_cfg = '0;
    end else if (e) begin
      ecyc++;
      if (pend.size() > 0 && pend[0].idx + L == ecyc) begin
        exp_valid = 1'b1;
        exp_r     = ref_result(pend[0].c, pend[0].f, pend[0].p);
        exp_cfg   = pend[0].c;
        void'(pend.pop_front());
      end else begin
        exp_valid = 1'b0;
      end
      if (iv) pend.push_back('{idx: ecyc, c: c, f: f, p: p});
    end
    #1;
  endtask

  // Issues one operation then idles; reports first out_valid cycle (1 = cycle after issue).
  task automatic issue_and_drain(input logic [3:0] c, input logic [3:0] f, input logic [63:0] p,
                                 output int lat, output int pulses, output logic [63:0] got,
                                 output logic [3:0] got_cfg);
    lat = 0; pulses = 0; got = 'x; got_cfg = 'x;
    cycle(1'b1, 1'b1, 1'b0, c, f, p);
    if (out_valid) begin lat = 1; pulses++; got = r_all; got_cfg = cfg_out_obs; end
    for (int j = 1; j <= L + 4; j++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 64'h0);
      if (out_valid) begin
        pulses++;
        if (lat == 0) begin lat = j + 1; got = r_all; got_cfg = cfg_out_obs; end
      end
    end
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 64'h0);
    cycle(1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 64'h0);
    nchk++;
    if (out_valid !== 1'b0 || r_all !== 64'h0 || cfg_out_obs !== 4'h0) begin
      nbad++;
      $display("FAIL reset: out_valid=%b r=%h cfg_out=%h required 0/0/0",
               out_valid, r_all, cfg_out_obs);
    end
  endtask

  task automatic test_directed;
    int lat, pulses;
    logic [63:0] got;
    logic [3:0] gc;
    logic [3:0]  cs [6] = '{4'b1000, 4'b1001, 4'b1001, 4'b1010, 4'b1010, 4'b0001};
    logic [3:0]  fs [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b0000, 4'b1111};
    logic [63:0] ps [6] = '{64'h0000_0000_0006_0006, 64'h0000_0000_0001_0000,
                            64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001,
                            64'h0000_0000_0000_0001, 64'h0000_0000_0000_1234};
    logic [63:0] es [6] = '{64'h0000_0000_0006_FFFA, 64'h0000_0000_FFFF_0000,
                            64'h0000_0000_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'h0000_0000_0000_0001, 64'h0000_0000_0000_1234};
    for (int k = 0; k < 6; k++) begin
      issue_and_drain(cs[k], fs[k], ps[k], lat, pulses, got, gc);
      nchk++;
      if (lat != L + 1 || pulses != 1) begin
        nbad++;
        $display("FAIL directed%0d timing: latency=%0d pulses=%0d required %0d/1",
                 k, lat, pulses, L + 1);
      end
      nchk++;
      if (got !== es[k]) begin
        nbad++;
        $display("FAIL directed%0d data: got %h required %h", k, got, es[k]);
      end
`ifdef MAC_SIGN_RESTORE_CFG_OUT_EN
      nchk++;
      if (gc !== cs[k]) begin
        nbad++;
        $display("FAIL directed%0d cfg_out: got %h required %h", k, gc, cs[k]);
      end
`endif
    end
  endtask

  task automatic test_stall;
    int vcyc[$];
    // cycles 0,1 issue; 2..4 stalled (in_valid high but must be dropped); then drain
    for (int t = 0; t < 14; t++) begin
      logic e, iv;
      logic [63:0] p;
      e  = !(t >= 2 && t <= 4);
      iv = (t <= 4);
      p  = {$urandom, $urandom};
      cycle(e, iv, 1'b0, 4'b1000 | 4'(t % 3), 4'($urandom), p);
      nchk++;
      if (out_valid !== exp_valid || r_all !== exp_r) begin
        nbad++;
        $display("FAIL stall t=%0d: out_valid=%b r=%h required %b/%h",
                 t, out_valid, r_all, exp_valid, exp_r);
      end
      if (out_valid && !(t >= 1 && t <= 4)) vcyc.push_back(t + 1);
      else if (out_valid) vcyc.push_back(-(t + 1));
    end
    nchk++;
    if (vcyc.size() != 2 || vcyc[0] != L + 4 || vcyc[1] != L + 5) begin
      nbad++;
      $display("FAIL stall timing: %0d pulses, first at cycle %0d, required 2 at %0d,%0d",
               vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1, L + 4, L + 5);
    end
  endtask

  task automatic test_reset_midflight;
    int lat, pulses;
    logic [63:0] got;
    logic [3:0] gc;
    cycle(1'b1, 1'b1, 1'b0, 4'b1000, 4'b0001, 64'h0000_0000_0000_0007);
    cycle(1'b1, 1'b1, 1'b1, 4'b1000, 4'b0001, 64'h0000_0000_0000_0007);
    for (int j = 0; j < L + 3; j++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 64'h0);
      nchk++;
      if (out_valid !== 1'b0 || r_all !== 64'h0) begin
        nbad++;
        $display("FAIL rst_midflight j=%0d: out_valid=%b r=%h required 0/0", j, out_valid, r_all);
      end
    end
    issue_and_drain(4'b1110, 4'b1000, 64'h0000_0000_0000_0005, lat, pulses, got, gc);
    nchk++;
    if (lat != L + 1 || pulses != 1 || got !== 64'hFFFF_FFFF_FFFF_FFFB) begin
      nbad++;
      $display("FAIL post_reset: latency=%0d pulses=%0d r=%h required %0d/1/%h",
               lat, pulses, got, L + 1, 64'hFFFF_FFFF_FFFF_FFFB);
    end
`ifdef MAC_SIGN_RESTORE_CFG_OUT_EN
    nchk++;
    if (gc !== 4'b1110) begin
      nbad++;
      $display("FAIL post_reset cfg_out: got %h required %h", gc, 4'b1110);
    end
`endif
  endtask

  task automatic test_random;
    for (int t = 0; t < 400; t++) begin
      logic [63:0] p;
      p = {$urandom, $urandom};
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) p[16*i +: 16] = 16'h0;
      cycle($urandom_range(0, 7) != 0, 1'($urandom), 1'b0, 4'($urandom), 4'($urandom), p);
      nchk++;
      if (out_valid !== exp_valid || r_all !== exp_r) begin
        nbad++;
        $display("FAIL random t=%0d: out_valid=%b r=%h required %b/%h",
                 t, out_valid, r_all, exp_valid, exp_r);
      end
`ifdef MAC_SIGN_RESTORE_CFG_OUT_EN
      nchk++;
      if (cfg_out_obs !== exp_cfg) begin
        nbad++;
        $display("FAIL random t=%0d cfg_out: got %h required %h", t, cfg_out_obs, exp_cfg);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
